// File: rtl/pipeline_stall_ctrl_if.sv
// Signal bundle between the pipeline stages and the central stall controller.
// The pipeline side is the master and the controller is the slave.
interface pipeline_stall_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             id_reg1_read_i;
  logic [4:0]       id_reg1_addr_i;
  logic             id_reg2_read_i;
  logic [4:0]       id_reg2_addr_i;
  logic             ex_is_load_i;
  logic             ex_wreg_i;
  logic [4:0]       ex_wd_i;
  logic             ex_stallreq_i;
  logic             mem_stallreq_i;
  logic [5:0]       stall_o;
  logic             load_bubble_o;
  logic [CNT_W-1:0] stall_cycles_o;
  logic [CNT_W-1:0] bubble_count_o;
  logic             timeout_o;

  modport master (
    output id_reg1_read_i, id_reg1_addr_i, id_reg2_read_i, id_reg2_addr_i,
    output ex_is_load_i, ex_wreg_i, ex_wd_i, ex_stallreq_i, mem_stallreq_i,
    input  stall_o, load_bubble_o, stall_cycles_o, bubble_count_o, timeout_o
  );

  modport slave (
    input  id_reg1_read_i, id_reg1_addr_i, id_reg2_read_i, id_reg2_addr_i,
    input  ex_is_load_i, ex_wreg_i, ex_wd_i, ex_stallreq_i, mem_stallreq_i,
    output stall_o, load_bubble_o, stall_cycles_o, bubble_count_o, timeout_o
  );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Central stall controller for the 5-stage MIPS pipeline: load-use bubble insertion,
// arbitration against EX/MEM stall requests, saturating statistics and an EX watchdog.
module pipeline_stall_ctrl #(
  parameter int CNT_W      = 32,
  parameter int EX_TIMEOUT = 64
) (
  input logic                 clk,
  input logic                 rst,
  pipeline_stall_ctrl_if.slave ctrl
);

  localparam int WD_W = $clog2(EX_TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    BUBBLE = 2'd1,
    EXWAIT = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic             hz_raw;
  logic             hz;
  logic             ex_only;
  logic [5:0]       stall;
  logic             bubble;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] bub_cnt;
  logic [WD_W-1:0]  wd_cnt, wd_cnt_nx;
  logic             timeout;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [WD_W-1:0] wd_inc(input logic [WD_W-1:0] v);
    return (v == WD_W'(EX_TIMEOUT)) ? v : v + WD_W'(1);
  endfunction

  always_comb begin
    hz_raw = ctrl.ex_is_load_i & ctrl.ex_wreg_i & (ctrl.ex_wd_i != 5'd0) &
             ((ctrl.id_reg1_read_i & (ctrl.id_reg1_addr_i == ctrl.ex_wd_i)) |
              (ctrl.id_reg2_read_i & (ctrl.id_reg2_addr_i == ctrl.ex_wd_i)));
    // EX already holds the NOP while in BUBBLE; a second bubble would be redundant.
    hz      = hz_raw & (state != BUBBLE);
    ex_only = ctrl.ex_stallreq_i & ~ctrl.mem_stallreq_i;
  end

  always_comb begin
    stall    = 6'b000000;
    bubble   = 1'b0;
    state_nx = state;
    if (ctrl.mem_stallreq_i) begin
      stall = 6'b011111;
    end else if (ctrl.ex_stallreq_i) begin
      stall = 6'b001111;
    end else if (hz) begin
      stall  = 6'b000111;
      bubble = 1'b1;
    end
    case (state)
      RUN: begin
        if (bubble)       state_nx = BUBBLE;
        else if (ex_only) state_nx = EXWAIT;
      end
      BUBBLE: begin
        state_nx = ex_only ? EXWAIT : RUN;
      end
      EXWAIT: begin
        // The hazard check stays live here, so a load-use pair waiting behind
        // a multi-cycle op still gets its bubble on the release cycle.
        if (!ctrl.ex_stallreq_i) state_nx = bubble ? BUBBLE : RUN;
      end
      default: state_nx = RUN;
    endcase
  end

  // The entry cycle counts toward the watchdog, so the flag rises on the
  // EX_TIMEOUT-th consecutive cycle of an EX stall.
  always_comb begin
    wd_cnt_nx = (state_nx == EXWAIT) ? wd_inc(wd_cnt) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      stall_cnt <= '0;
      bub_cnt   <= '0;
      wd_cnt    <= '0;
      timeout   <= 1'b0;
    end else begin
      state  <= state_nx;
      wd_cnt <= wd_cnt_nx;
      if (stall != 6'b000000) stall_cnt <= sat_inc(stall_cnt);
      if (bubble)             bub_cnt   <= sat_inc(bub_cnt);
      if (wd_cnt_nx == WD_W'(EX_TIMEOUT)) timeout <= 1'b1;
    end
  end

  assign ctrl.stall_o        = rst ? 6'b000000 : stall;
  assign ctrl.load_bubble_o  = rst ? 1'b0 : bubble;
  assign ctrl.stall_cycles_o = stall_cnt;
  assign ctrl.bubble_count_o = bub_cnt;
  assign ctrl.timeout_o      = timeout;

endmodule
